uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DIV_RATE, default 260, clock cycles per UART bit; legal range 2..511.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of transmit buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write strobe; pushes wr_data into buffer.
REQ-006 SHALL have port wr_data  input  8  byte to transmit.
REQ-007 SHALL have port full  output  1  buffer holds FIFO_DEPTH entries.
REQ-008 SHALL have port overflow  output  1  one-cycle pulse: write dropped while full.
REQ-009 SHALL have port tx_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port tx_end  output  1  one-cycle pulse at completion of each frame.
REQ-011 SHALL have port tx  output  1  serial line; idle high; registered.

Function
REQ-012 SHALL frame each byte as: start bit 0, 8 data bits LSB first, optional parity bit (REQ-027), stop bit 1.
REQ-013 SHALL hold every bit on tx for exactly DIV_RATE cycles, timed by a 9-bit down-counter reloaded at each bit boundary.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP. Transitions:
- IDLE->START when buffer non-empty.
- START->DATA after DIV_RATE cycles.
- DATA->PARITY or STOP after the 8th bit.
- PARITY->STOP after DIV_RATE cycles.
- STOP->START if buffer non-empty at the final stop cycle, else STOP->IDLE.
REQ-015 SHALL pop the buffer head into an 8-bit shift register on entry to START; tx goes low on the same edge.
REQ-016 SHALL have a write-to-tx latency on an empty buffer in IDLE of: write sampled at edge k -> tx low after edge k+1.
REQ-017 SHALL send back-to-back frames with no idle cycle between the stop bit and the next start bit.
REQ-018 SHALL assert tx_end for exactly one cycle, coincident with the last cycle of the stop bit.
REQ-019 SHALL handle a write while full as follows: data discarded, buffer unchanged, overflow high for one cycle.
REQ-020 SHALL handle a simultaneous write and pop when full as follows: pop first, write accepted, no overflow.
REQ-021 SHALL handle a simultaneous write and pop when empty as follows: not possible (pop requires non-empty); write accepted normally.
REQ-022 SHALL wrap buffer read/write pointers modulo FIFO_DEPTH, using a separate count of width log2(FIFO_DEPTH)+1.
REQ-023 SHALL assert full combinationally from the count only.

Reset
REQ-024 SHALL, on reset: tx=1, tx_busy=0, tx_end=0, overflow=0, full=0, state IDLE, buffer emptied, pointers 0, bit counter 0, div counter DIV_RATE-1.
REQ-025 SHALL, on reset asserted mid-frame: abort the frame, drive tx high on the next edge, discard buffered bytes, emit no tx_end.
REQ-026 SHALL give reset priority over wr_en in the same cycle (write lost, no overflow).

Configuration
REQ-027 SHALL, when UART_TX_PARITY_EN is defined: insert the PARITY state, sending even parity (XOR of the 8 data bits), for an 11-bit frame of 11*DIV_RATE cycles.
REQ-028 SHALL, when UART_TX_PARITY_EN is undefined: omit the PARITY state and parity logic entirely (DATA->STOP), for a 10-bit frame of 10*DIV_RATE cycles.

Verification
REQ-029 SHALL cover: DIV_RATE=4, no parity, write 0xA5 at edge k -> tx low after edge k+1; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop 1; tx_end at cycle 40 of the frame.
REQ-030 SHALL cover: DIV_RATE=4, write 0x00 then 0xFF in consecutive cycles -> two frames, 80 cycles total, no idle gap, two tx_end pulses 40 cycles apart.
REQ-031 SHALL cover: FIFO_DEPTH=4, 6 writes in consecutive cycles while idle -> first popped; 4 buffered, full=1; 6th write -> overflow pulse; exactly 5 frames transmitted.
REQ-032 SHALL cover: reset asserted at cycle 15 of a frame -> tx=1, tx_busy=0, buffer empty next cycle; no tx_end; line stays high.
REQ-033 SHALL cover: UART_TX_PARITY_EN defined, DIV_RATE=4, byte 0x07 -> parity bit 1 at cycles 36-39; tx_end at cycle 44.
REQ-034 SHALL cover: full buffer with a write on the same cycle as a pop at frame end -> write accepted, overflow=0, full stays 1.

Source files
------------

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//
// Purpose: buffered UART transmitter. Bytes written through wr_en/wr_data
// go into a small FIFO. A framing FSM pops them one at a time and drives
// them out on tx as: start bit (0), 8 data bits LSB first, an optional
// even-parity bit, and a stop bit (1). Each bit lasts DIV_RATE clock cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit
// (11-bit frame). When it is undefined the frame is 10 bits and no parity
// logic exists.
//
// Parameters:
//   DIV_RATE   - clock cycles per UART bit (2..511)
//   FIFO_DEPTH - transmit buffer entries (power of two, 2..16)
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   wr_en    in   write strobe; pushes wr_data into the buffer
//   wr_data  in   byte to transmit
//   full     out  buffer holds FIFO_DEPTH entries (combinational from count)
//   overflow out  one-cycle pulse: a write was dropped because the buffer was full
//   tx_busy  out  high while the FSM is not IDLE
//   tx_end   out  one-cycle pulse during the last cycle of each stop bit
//   tx       out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_buf #(
    parameter int DIV_RATE   = 260,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       tx_busy,
    output logic       tx_end,
    output logic       tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [8:0]       DIV_RELOAD = 9'(DIV_RATE - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Buffer storage and pointers; pointers wrap naturally at FIFO_DEPTH.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t     state_q, state_d;
    logic [8:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic [7:0] head;
    logic       not_empty;
    logic       bit_done;
    logic       pop;
    logic       push;

    assign head      = mem[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign bit_done  = (div_cnt_q == 9'd0);
    assign full      = (count_q == DEPTH_CNT);

    // A pop happens only where a new frame begins: from IDLE, or on the
    // final stop cycle so consecutive frames abut with no idle gap.
    assign pop  = not_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
    // The pop frees a slot in the same cycle, so a write while full is still
    // accepted when it coincides with a pop.
    assign push = wr_en && (!full || pop);

    assign overflow_d = wr_en && full && !pop;

    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_end   = (state_q == STOP) && bit_done;

    // Buffer bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Framing FSM. tx_d is the line value for the state being entered, so
    // tx_q and state_q always change on the same edge.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) begin
            div_cnt_d = bit_done ? DIV_RELOAD : (div_cnt_q - 9'd1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d   = START;
                    tx_d      = 1'b0;
                    shift_d   = head;
                    div_cnt_d = DIV_RELOAD;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^head;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (pop) begin
                        state_d  = START;
                        tx_d     = 1'b0;
                        shift_d  = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                tx_d      = 1'b1;
                div_cnt_d = DIV_RELOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= DIV_RELOAD;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, overflow, tx_busy, tx_end, tx;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int end_cnt = 0;
    logic rx_active = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       shape_ok;
        logic       end_ok;
        int         start_cyc;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_buf #(.DIV_RATE(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .tx_busy  (tx_busy),
        .tx_end   (tx_end),
        .tx       (tx)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Line monitor: samples tx at each falling edge, captures a whole frame
    // from the start bit and decodes it independently of the DUT internals.
    initial begin : monitor
        logic samp [FRAME_CYC];
        logic ends [FRAME_CYC];
        int   idx;
        int   start;
        logic v;
        frame_t f;
        idx = 0;
        start = 0;
        forever begin
            @(negedge clk);
            if (tx_end === 1'b1) end_cnt++;
            if (reset === 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active && tx === 1'b0) begin
                rx_active = 1'b1;
                idx = 0;
                start = cyc;
            end
            if (rx_active) begin
                samp[idx] = tx;
                ends[idx] = tx_end;
                idx++;
                if (idx == FRAME_CYC) begin
                    rx_active = 1'b0;
                    f.data = 8'h00;
                    f.shape_ok = 1'b1;
                    f.end_ok = 1'b1;
                    f.start_cyc = start;
                    f.par = samp[9*DIV];
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        v = samp[b*DIV];
                        for (int j = 0; j < DIV; j++)
                            if (samp[b*DIV+j] !== v) f.shape_ok = 1'b0;
                        if (b >= 1 && b <= 8) f.data[b-1] = v;
                    end
                    if (samp[0] !== 1'b0) f.shape_ok = 1'b0;
                    if (samp[FRAME_CYC-1] !== 1'b1) f.shape_ok = 1'b0;
`ifdef UART_TX_PARITY_EN
                    if (f.par !== ^f.data) f.shape_ok = 1'b0;
`endif
                    for (int j = 0; j < FRAME_CYC; j++)
                        if (ends[j] !== ((j == FRAME_CYC-1) ? 1'b1 : 1'b0)) f.end_ok = 1'b0;
                    rx_q.push_back(f);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_end !== 1'b0)  begin failures++; $display("FAIL reset_tx_end: got %b expected 0", tx_end); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (full !== 1'b0)    begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
        reset = 1'b0;
        $display("reset done at cycle %0d", cyc);
    endtask

    task automatic test_single(input logic [7:0] d);
        int k, t, e0;
        frame_t f;
        logic [7:0] e;
        rx_q.delete();
        exp_q.delete();
        e0 = end_cnt;
        @(posedge clk); #1;
        k = cyc + 1;
        wr_en = 1'b1; wr_data = d; exp_q.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        t = 0;
        while (rx_q.size() < 1 && t < FRAME_CYC*3) begin @(posedge clk); #1; t++; end
        checks++;
        if (rx_q.size() < 1) begin
            failures++; $display("FAIL single_timeout: got %0d frames expected 1", rx_q.size());
        end else begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            $display("frame byte=%02h start=%0d write_edge=%0d", f.data, f.start_cyc, k);
            checks++; if (f.data !== e) begin failures++; $display("FAIL single_data: got %02h expected %02h", f.data, e); end
            checks++; if (f.shape_ok !== 1'b1) begin failures++; $display("FAIL single_shape: got %b expected 1", f.shape_ok); end
            checks++; if (f.end_ok !== 1'b1) begin failures++; $display("FAIL single_tx_end_pos: got %b expected 1", f.end_ok); end
            checks++; if (f.start_cyc !== k + 1) begin failures++; $display("FAIL single_latency: got %0d expected %0d", f.start_cyc, k + 1); end
`ifdef UART_TX_PARITY_EN
            checks++; if (f.par !== ^d) begin failures++; $display("FAIL single_parity: got %b expected %b", f.par, ^d); end
`endif
        end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b expected 0", tx_busy); end
        checks++; if (end_cnt - e0 !== 1) begin failures++; $display("FAIL single_end_count: got %0d expected 1", end_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int k, t, e0;
        frame_t f0, f1;
        logic [7:0] x0, x1;
        rx_q.delete();
        exp_q.delete();
        e0 = end_cnt;
        @(posedge clk); #1;
        k = cyc + 1;
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        @(posedge clk); #1;
        wr_data = 8'hFF; exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        wr_en = 1'b0;
        t = 0;
        while (rx_q.size() < 2 && t < FRAME_CYC*4) begin @(posedge clk); #1; t++; end
        checks++;
        if (rx_q.size() < 2) begin
            failures++; $display("FAIL b2b_timeout: got %0d frames expected 2", rx_q.size());
        end else begin
            f0 = rx_q.pop_front(); x0 = exp_q.pop_front();
            f1 = rx_q.pop_front(); x1 = exp_q.pop_front();
            $display("frame byte=%02h start=%0d", f0.data, f0.start_cyc);
            $display("frame byte=%02h start=%0d", f1.data, f1.start_cyc);
            checks++; if (f0.data !== x0) begin failures++; $display("FAIL b2b_data0: got %02h expected %02h", f0.data, x0); end
            checks++; if (f1.data !== x1) begin failures++; $display("FAIL b2b_data1: got %02h expected %02h", f1.data, x1); end
            checks++; if ((f0.shape_ok & f1.shape_ok) !== 1'b1) begin failures++; $display("FAIL b2b_shape: got %b%b expected 11", f0.shape_ok, f1.shape_ok); end
            checks++; if ((f0.end_ok & f1.end_ok) !== 1'b1) begin failures++; $display("FAIL b2b_tx_end_pos: got %b%b expected 11", f0.end_ok, f1.end_ok); end
            checks++; if (f0.start_cyc !== k + 1) begin failures++; $display("FAIL b2b_start0: got %0d expected %0d", f0.start_cyc, k + 1); end
            checks++; if (f1.start_cyc !== f0.start_cyc + FRAME_CYC) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", f1.start_cyc, f0.start_cyc + FRAME_CYC); end
        end
        checks++; if (end_cnt - e0 !== 2) begin failures++; $display("FAIL b2b_end_count: got %0d expected 2", end_cnt - e0); end
    endtask

    task automatic test_overflow;
        int k, t;
        logic [7:0] d [6];
        frame_t f;
        logic [7:0] e;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        k = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = d[i];
            if (i < 5) exp_q.push_back(d[i]);
            @(posedge clk); #1;
            if (i == 3) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL ovf_full_at3: got %b expected 0", full); end
            end
            if (i == 4) begin
                checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full_at4: got %b expected 1", full); end
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (i == 5) begin
                checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
            end
        end
        wr_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_width: got %b expected 0", overflow); end
        // Land a write on the edge that pops the next byte at the end of frame 1.
        while (cyc < k + FRAME_CYC) begin @(posedge clk); #1; end
        checks++; if (tx_end !== 1'b1) begin failures++; $display("FAIL ovf_tx_end_frame1: got %b expected 1", tx_end); end
        wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL popwrite_overflow: got %b expected 0", overflow); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL popwrite_full: got %b expected 1", full); end
        t = 0;
        while (rx_q.size() < 6 && t < FRAME_CYC*8) begin @(posedge clk); #1; t++; end
        checks++;
        if (rx_q.size() < 6) begin
            failures++; $display("FAIL ovf_timeout: got %0d frames expected 6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                $display("frame byte=%02h start=%0d", f.data, f.start_cyc);
                checks++; if (f.data !== e) begin failures++; $display("FAIL ovf_data%0d: got %02h expected %02h", i, f.data, e); end
                checks++; if (f.start_cyc !== k + 1 + i*FRAME_CYC) begin failures++; $display("FAIL ovf_start%0d: got %0d expected %0d", i, f.start_cyc, k + 1 + i*FRAME_CYC); end
                checks++; if ((f.shape_ok & f.end_ok) !== 1'b1) begin failures++; $display("FAIL ovf_frame%0d: got shape=%b end=%b expected 1 1", i, f.shape_ok, f.end_ok); end
            end
        end
        repeat (FRAME_CYC*2) begin @(posedge clk); #1; end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL ovf_extra_frames: got %0d expected 0", rx_q.size()); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_after: got %b expected 0", tx_busy); end
    endtask

    task automatic test_reset_mid_frame;
        int k, e0, low;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        k = cyc + 1;
        wr_en = 1'b1; wr_data = 8'h3C;
        @(posedge clk); #1;
        wr_data = 8'hC3;
        @(posedge clk); #1;
        wr_en = 1'b0;
        e0 = end_cnt;
        // Frame cycle 15 is the cycle after edge k+15.
        while (cyc < k + 15) begin @(posedge clk); #1; end
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", tx_busy); end
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
        @(posedge clk); #1;
        reset = 1'b0; wr_en = 1'b0;
        $display("reset mid-frame at cycle %0d", cyc);
        checks++; if (tx !== 1'b1)       begin failures++; $display("FAIL midrst_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
        checks++; if (full !== 1'b0)     begin failures++; $display("FAIL midrst_full: got %b expected 0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
        low = 0;
        repeat (FRAME_CYC*3) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || tx_busy !== 1'b0) low++;
        end
        checks++; if (low !== 0) begin failures++; $display("FAIL midrst_line_active: got %0d active cycles expected 0", low); end
        checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL midrst_frames: got %0d expected 0", rx_q.size()); end
        checks++; if (end_cnt !== e0) begin failures++; $display("FAIL midrst_tx_end: got %0d pulses expected 0", end_cnt - e0); end
    endtask

    initial begin
        test_reset;
        test_single(8'hA5);
        test_single(8'h07);
        test_back_to_back;
        test_overflow;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
